// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces press and release, and hands out one 4-bit code per press
// (code = row*4 + col) through a single-entry valid/ready buffer.
// Optional feature: define KEY_REPEAT_EN to re-emit the code of a held key
// after REPEAT_DELAY column steps and then every REPEAT_RATE steps.
module keypad_scanner #(
   parameter int SCAN_DIV     = 65536,
   parameter int DEBOUNCE_CNT = 4,
   parameter int REPEAT_DELAY = 32,
   parameter int REPEAT_RATE  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       overflow,
   input  logic       ovf_clr
);

   localparam int DIV_W = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_HELD
   } state_t;

   // Reject configurations the scan and debounce counters cannot represent.
   if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15 ||
       REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
      $error("keypad_scanner: illegal parameter value");
   end

   logic [3:0]       sync1_q, sync2_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;
   state_t           state_q, state_d;
   logic [1:0]       col_q, col_d;
   logic [3:0]       col_out_q, col_out_d;
   logic [1:0]       cand_row_q, cand_row_d;
   logic [3:0]       match_q, match_d;
   logic [3:0]       rel_q, rel_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             overflow_q, overflow_d;

   logic             rows_idle;
   logic [1:0]       hit_row;
   logic             cand_low;
   logic [3:0]       match_inc, rel_inc;
   logic             deb_emit, rpt_emit, emit;
   logic             advance;
   logic             transfer;
   logic             ovf_set;

   assign tick      = (div_q == DIV_W'(SCAN_DIV - 1));
   assign div_d     = tick ? '0 : div_q + 1'b1;
   assign rows_idle = &sync2_q;
   assign cand_low  = ~sync2_q[cand_row_q];
   assign match_inc = match_q + 4'd1;
   assign rel_inc   = rel_q + 4'd1;
   assign transfer  = key_valid_q & key_ready;
   assign emit      = deb_emit | rpt_emit;

   // Row decode: the lowest-index low row wins when several are pressed.
   always_comb begin
      if (!sync2_q[0])      hit_row = 2'd0;
      else if (!sync2_q[1]) hit_row = 2'd1;
      else if (!sync2_q[2]) hit_row = 2'd2;
      else                  hit_row = 2'd3;
   end

   // Scan/debounce/held sequencing, evaluated only on column-step ticks.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      col_d      = col_q;
      col_out_d  = col_out_q;
      cand_row_d = cand_row_q;
      match_d    = match_q;
      rel_d      = rel_q;
      deb_emit   = 1'b0;
      advance    = 1'b0;
      if (tick) begin
         case (state_q)
            ST_SCAN: begin
               if (!rows_idle) begin
                  cand_row_d = hit_row;
                  match_d    = '0;
                  state_d    = ST_DEBOUNCE;
               end else begin
                  advance = 1'b1;
               end
            end
            ST_DEBOUNCE: begin
               if (cand_low) begin
                  match_d = match_inc;
                  if (match_inc == 4'(DEBOUNCE_CNT)) begin
                     deb_emit = 1'b1;
                     rel_d    = '0;
                     state_d  = ST_HELD;
                  end
               end else begin
                  state_d = ST_SCAN;
                  advance = 1'b1;
               end
            end
            ST_HELD: begin
               if (rows_idle) begin
                  rel_d = rel_inc;
                  if (rel_inc == 4'(DEBOUNCE_CNT)) begin
                     rel_d   = '0;
                     state_d = ST_SCAN;
                     advance = 1'b1;
                  end
               end else begin
                  rel_d = '0;
               end
            end
            default: state_d = ST_SCAN;
         endcase
      end
      if (advance) begin
         col_d     = col_q + 2'd1;
         col_out_d = {col_out_q[2:0], col_out_q[3]};
      end
   end

`ifdef KEY_REPEAT_EN
   logic [15:0] rpt_q, rpt_d, rpt_inc;
   logic        rpt_armed_q, rpt_armed_d;

   assign rpt_inc = rpt_q + 16'd1;

   // Auto-repeat timing: first repeat after REPEAT_DELAY held ticks, then every REPEAT_RATE.
   always_comb begin
      rpt_d       = rpt_q;
      rpt_armed_d = rpt_armed_q;
      rpt_emit    = 1'b0;
      if (state_q != ST_HELD) begin
         rpt_d       = '0;
         rpt_armed_d = 1'b0;
      end else if (tick) begin
         if (rows_idle) begin
            rpt_d = '0;
         end else if (cand_low) begin
            if ((!rpt_armed_q && rpt_inc == 16'(REPEAT_DELAY)) ||
                ( rpt_armed_q && rpt_inc == 16'(REPEAT_RATE))) begin
               rpt_emit    = 1'b1;
               rpt_d       = '0;
               rpt_armed_d = 1'b1;
            end else begin
               rpt_d = rpt_inc;
            end
         end
      end
   end

   // Repeat counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_q       <= '0;
         rpt_armed_q <= 1'b0;
      end else begin
         rpt_q       <= rpt_d;
         rpt_armed_q <= rpt_armed_d;
      end
   end
`else
   assign rpt_emit = 1'b0;
`endif

   // One-entry output buffer; a code arriving while the buffer is full is dropped.
   always_comb begin
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      ovf_set     = 1'b0;
      if (emit) begin
         if (!key_valid_q || transfer) begin
            key_code_d  = {cand_row_q, col_q};
            key_valid_d = 1'b1;
         end else begin
            ovf_set = 1'b1;
         end
      end else if (transfer) begin
         key_valid_d = 1'b0;
      end
      // A drop on the same edge as a clear leaves overflow set.
      overflow_d = ovf_set | (overflow_q & ~ovf_clr);
   end

   // All scanner state: synchronizer, divider, FSM and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 4'hF;
         sync2_q     <= 4'hF;
         div_q       <= '0;
         state_q     <= ST_SCAN;
         col_q       <= 2'd0;
         col_out_q   <= 4'b1110;
         cand_row_q  <= 2'd0;
         match_q     <= '0;
         rel_q       <= '0;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values, as the hardware does.
         sync1_q     <= row_in;
         sync2_q     <= sync1_q;
         div_q       <= div_d;
         state_q     <= state_d;
         col_q       <= col_d;
         col_out_q   <= col_out_d;
         cand_row_q  <= cand_row_d;
         match_q     <= match_d;
         rel_q       <= rel_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign col_out   = col_out_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign overflow  = overflow_q;

endmodule
